sram_64x24_1p_ctrl: RTL and testbench

Front-end controller for a 64-entry × 24-bit single-port, one-cycle-read-latency SRAM macro. It sits directly upstream of the array and drives the array's address, enable, write-mode, mask and write-data pins. After reset it zero-initialises the array, then arbitrates separate read and write request channels onto the single port. It returns read data through a hold register, so the data stays stable after the access cycle.

---
 rtl/sram_64x24_1p_ctrl_if.sv | 27 ++
 rtl/sram_64x24_1p_ctrl.sv | 103 ++++++++++
 tb/tb_sram_64x24_1p_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_64x24_1p_ctrl_if.sv
// Request/response bundle between a requester and the SRAM front-end controller.
interface sram_64x24_1p_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 24
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic              w_mask;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic [WIDTH-1:0]  resp_data;
  logic              init_done;

  modport master (
    output w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    input  w_ready, r_ready, resp_valid, resp_data, init_done
  );

  modport slave (
    input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr,
    output w_ready, r_ready, resp_valid, resp_data, init_done
  );
endinterface

// File: rtl/sram_64x24_1p_ctrl.sv
// Single-port SRAM front end: clears the array after reset, then arbitrates
// write (priority) and read channels onto the macro port and returns read
// data through a hold register.
//
// state | meaning
// RST   | reset value, macro idle for one cycle
// CLEAR | writing zero to every entry, clr_cnt is the address
// READY | serving requests, terminal until reset
module sram_64x24_1p_ctrl #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 6
) (
  input  logic              RW0_clk,
  input  logic              rst,
  sram_64x24_1p_ctrl_if.slave bus,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wmask,
  output logic [WIDTH-1:0]  sram_wdata,
  input  logic [WIDTH-1:0]  sram_rdata
);

  typedef enum logic [1:0] {RST, CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              rd_pend_q;
  logic [WIDTH-1:0]  hold_q;
  logic              w_fire, r_fire, clr_last;

  assign clr_last = (clr_cnt_q == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) state_q <= RST;
    else     state_q <= state_d;
  end

  // Clear counter, pending-read flag and read-data hold register.
  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (state_q == CLEAR && !clr_last) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      rd_pend_q <= r_fire;
      if (rd_pend_q) hold_q <= sram_rdata;
    end
  end

  // Next state, handshake and macro pin drive; writes win over reads.
  always_comb begin
    state_d        = state_q;
    w_fire         = 1'b0;
    r_fire         = 1'b0;
    bus.w_ready    = 1'b0;
    bus.r_ready    = 1'b0;
    bus.init_done  = 1'b0;
    sram_en        = 1'b0;
    sram_wmode     = 1'b0;
    sram_addr      = '0;
    sram_wmask     = 1'b0;
    sram_wdata     = '0;
    case (state_q)
      RST: state_d = CLEAR;
      CLEAR: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_wmask = 1'b1;
        sram_addr  = clr_cnt_q;
        if (clr_last) state_d = READY;
      end
      READY: begin
        bus.init_done = 1'b1;
        bus.w_ready   = 1'b1;
        bus.r_ready   = !bus.w_valid;
        w_fire        = bus.w_valid;
        r_fire        = bus.r_valid && !bus.w_valid;
        if (w_fire) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = bus.w_addr;
          sram_wmask = bus.w_mask;
          sram_wdata = bus.w_data;
        end else if (r_fire) begin
          sram_en   = 1'b1;
          sram_addr = bus.r_addr;
        end
      end
      default: state_d = RST;
    endcase
  end

  // Fresh macro data bypasses the hold register in the response cycle.
  always_comb begin
    bus.resp_valid = rd_pend_q;
    bus.resp_data  = rd_pend_q ? sram_rdata : hold_q;
  end

endmodule

// File: tb/tb_sram_64x24_1p_ctrl.sv
// Directed bench for sram_64x24_1p_ctrl with a behavioural SRAM macro and a
// queue of expected read responses.
module tb_sram_64x24_1p_ctrl;
  localparam int DEPTH  = 64;
  localparam int WIDTH  = 24;
  localparam int ADDR_W = 6;

  logic              RW0_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              sram_en, sram_wmode, sram_wmask;
  logic [ADDR_W-1:0] sram_addr;
  logic [WIDTH-1:0]  sram_wdata;
  logic [WIDTH-1:0]  sram_rdata;

  logic [WIDTH-1:0]  mem     [DEPTH];
  logic [WIDTH-1:0]  ref_mem [DEPTH];
  logic [WIDTH-1:0]  exp_q   [$];

  int pass_cnt  = 0;
  int check_cnt = 0;

  sram_64x24_1p_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

  sram_64x24_1p_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .RW0_clk    (RW0_clk),
    .rst        (rst),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 RW0_clk = ~RW0_clk;

  // Macro model: one-cycle read latency, write on the enable edge, unaffected by rst.
  always @(posedge RW0_clk) begin
    if (sram_en && sram_wmode && sram_wmask) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding read.
  always @(negedge RW0_clk) begin
    if (!rst && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("resp_spurious", {23'd0, bus.resp_valid}, 24'd0);
      else check("resp_sb", bus.resp_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge RW0_clk);
    #1;
  endtask

  // Release reset before the next edge and follow the 65-edge clear.
  task automatic init_seq();
    rst = 1'b0;
    #1;
    check("rst_sram_en", {23'd0, sram_en}, 24'd0);
    for (int k = 1; k <= 65; k++) begin
      step();
      if (k <= 64) begin
        check("clr_en",    {23'd0, sram_en}, 24'd1);
        check("clr_addr",  {18'd0, sram_addr}, 24'(k - 1));
        check("clr_done0", {23'd0, bus.init_done}, 24'd0);
        if (k == 1 || k == 64) begin
          check("clr_wdata", sram_wdata, 24'd0);
          check("clr_wmask", {23'd0, sram_wmask}, 24'd1);
          check("clr_wready", {23'd0, bus.w_ready}, 24'd0);
        end
      end else begin
        check("init_done", {23'd0, bus.init_done}, 24'd1);
        check("init_wready", {23'd0, bus.w_ready}, 24'd1);
        check("init_en_idle", {23'd0, sram_en}, 24'd0);
      end
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic m);
    bus.w_valid = 1'b1; bus.w_addr = a; bus.w_data = d; bus.w_mask = m;
    #1;
    check("wr_ready", {23'd0, bus.w_ready}, 24'd1);
    check("wr_pins", {sram_en, sram_wmode, sram_wmask, sram_addr, 15'd0},
          {1'b1, 1'b1, m, a, 15'd0});
    check("wr_wdata", sram_wdata, d);
    step();
    bus.w_valid = 1'b0;
    if (m) ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] e;
    bus.r_valid = 1'b1; bus.r_addr = a;
    #1;
    check("rd_ready", {23'd0, bus.r_ready}, 24'd1);
    check("rd_pins", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, a});
    e = ref_mem[a];
    exp_q.push_back(e);
    step();
    bus.r_valid = 1'b0;
    check("rd_resp_valid", {23'd0, bus.resp_valid}, 24'd1);
    check("rd_resp_data", bus.resp_data, e);
  endtask

  initial begin
    bus.w_valid = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.w_mask = 1'b0;
    bus.r_valid = 1'b0; bus.r_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 24'hFFFFFF;
    sram_rdata = 24'hFFFFFF;
    #1;
    check("reset_outs", {bus.w_ready, bus.r_ready, bus.resp_valid, bus.init_done,
                         sram_en, sram_wmode, sram_wmask, 17'd0}, 24'd0);
    check("reset_resp_data", bus.resp_data, 24'd0);
    check("reset_sram_addr", {18'd0, sram_addr}, 24'd0);
    check("reset_sram_wdata", sram_wdata, 24'd0);
    step();
    step();
    init_seq();

    // Cleared array reads back zero.
    do_read(6'd0);
    do_read(6'd63);
    do_read(6'd31);

    // Write then immediate read returns new data, and holds while idle.
    do_write(6'd5, 24'hABCDEF, 1'b1);
    do_read(6'd5);
    for (int i = 0; i < 10; i++) step();
    check("hold_idle_data", bus.resp_data, 24'hABCDEF);
    check("hold_idle_valid", {23'd0, bus.resp_valid}, 24'd0);

    // Masked write leaves the entry untouched.
    do_write(6'd7, 24'h123456, 1'b0);
    do_read(6'd7);
    step();

    // Write has priority; read stalls then fires.
    bus.w_valid = 1'b1; bus.w_addr = 6'd3; bus.w_data = 24'h000111; bus.w_mask = 1'b1;
    bus.r_valid = 1'b1; bus.r_addr = 6'd3;
    #1;
    check("prio_r_ready", {23'd0, bus.r_ready}, 24'd0);
    check("prio_w_ready", {23'd0, bus.w_ready}, 24'd1);
    check("prio_pins", {sram_wmode, sram_addr}, {1'b1, 6'd3});
    step();
    bus.w_valid = 1'b0;
    ref_mem[3] = 24'h000111;
    check("prio_no_resp", {23'd0, bus.resp_valid}, 24'd0);
    do_read(6'd3);
    step();

    // Read followed by a write to the same address keeps the old data.
    do_write(6'd9, 24'h00AA55, 1'b1);
    bus.r_valid = 1'b1; bus.r_addr = 6'd9;
    exp_q.push_back(ref_mem[9]);
    step();
    bus.r_valid = 1'b0;
    bus.w_valid = 1'b1; bus.w_addr = 6'd9; bus.w_data = 24'hFFFFFF; bus.w_mask = 1'b1;
    #1;
    check("wr_after_rd_valid", {23'd0, bus.resp_valid}, 24'd1);
    check("wr_after_rd_data", bus.resp_data, 24'h00AA55);
    step();
    bus.w_valid = 1'b0;
    ref_mem[9] = 24'hFFFFFF;
    check("hold_after_wr", bus.resp_data, 24'h00AA55);
    step();
    step();
    check("hold_after_wr2", bus.resp_data, 24'h00AA55);

    // Back-to-back reads.
    bus.r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.r_addr = (i == 0) ? 6'd5 : (i == 1) ? 6'd9 : (i == 2) ? 6'd3 : 6'd7;
      #1;
      check("b2b_r_ready", {23'd0, bus.r_ready}, 24'd1);
      if (i > 0) check("b2b_resp_valid", {23'd0, bus.resp_valid}, 24'd1);
      exp_q.push_back(ref_mem[bus.r_addr]);
      step();
    end
    bus.r_valid = 1'b0;
    step();
    check("b2b_drained", {23'd0, bus.resp_valid}, 24'd0);

    // Reset in the response cycle of a read.
    do_write(6'd20, 24'h0BEEF0, 1'b1);
    bus.r_valid = 1'b1; bus.r_addr = 6'd20;
    step();
    bus.r_valid = 1'b0;
    check("mid_resp_before", {23'd0, bus.resp_valid}, 24'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_resp_valid", {23'd0, bus.resp_valid}, 24'd0);
    check("mid_resp_data", bus.resp_data, 24'd0);
    check("mid_init_done", {23'd0, bus.init_done}, 24'd0);
    check("mid_ready", {22'd0, bus.w_ready, bus.r_ready}, 24'd0);
    check("mid_sram_en", {23'd0, sram_en}, 24'd0);
    step();
    init_seq();
    do_read(6'd20);
    do_read(6'd5);
    step();

    check("sb_drained", 24'(exp_q.size()), 24'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
